// File: rtl/arq_pkg.sv
// Shared types and constants for the go-back-N ARQ replay buffer.
package arq_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } arq_state_e;

    localparam logic ACK_CODE = 1'b0;
    localparam logic NAK_CODE = 1'b1;

    localparam int unsigned DEF_WINDOW    = 4;
    localparam int unsigned DEF_FRAME_LEN = 16;
    localparam int unsigned DEF_PTR_W     = $clog2(DEF_WINDOW) + 1;
    localparam int unsigned DEF_OFF_W     = $clog2(DEF_FRAME_LEN);

    // One extra MSB keeps full and empty distinguishable after wrap-around.
    function automatic int unsigned ptr_width(input int unsigned window);
        return $clog2(window) + 1;
    endfunction

endpackage

// File: rtl/arq_replay_ram.sv
// Frame store: simple dual-port RAM, one write port and one registered read port.
module arq_replay_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // Read data holds while re is low, which keeps a stalled beat stable.
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/arq_replay_buffer.sv
// Go-back-N ARQ transmit buffer: stores up to WINDOW frames and replays from the oldest
// unacknowledged one on NAK or timeout. Optional counters: ARQ_REPLAY_STATS_EN.
module arq_replay_buffer
    import arq_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned WINDOW    = 4,
    parameter int unsigned TIMEOUT   = 4096,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_valid,
    input  logic                          i_sof,
    output logic                          o_ready,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_valid,
    output logic                          o_sof,
    input  logic                          i_ready,
    input  logic                          i_ack_valid,
    input  logic                          i_ack_nak,
    input  logic                          i_arq_en,
    output logic [$clog2(WINDOW):0]       o_frames_held,
    output logic                          o_retrans,
    output logic                          o_err
`ifdef ARQ_REPLAY_STATS_EN
    ,
    output logic [31:0]                   o_stat_tx_frames,
    output logic [15:0]                   o_stat_retrans,
    output logic [15:0]                   o_stat_drops
`endif
);

    localparam int unsigned IDX_W = $clog2(WINDOW);
    localparam int unsigned PTR_W = ptr_width(WINDOW);
    localparam int unsigned OFF_W = $clog2(FRAME_LEN);
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(WINDOW);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    arq_state_e        st_q, st_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, snd_ptr_q, snd_ptr_d, ack_ptr_q, ack_ptr_d;
    logic [OFF_W-1:0]  wr_off_q, wr_off_d, rd_off_q, rd_off_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic              rewind_q, rewind_d, arq_en_q, arq_en_d;
    logic              valid_q, valid_d, sof_q, sof_d, ready_q, ready_d;
    logic              retrans_q, retrans_d, err_q, err_d;

    logic              wr_en, wr_restart;
    logic [OFF_W-1:0]  wr_addr_off;
    logic              re;
    logic [IDX_W+OFF_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;

    logic              hs, last_beat, frame_done, boundary;
    logic              ack_evt, nak_evt, tmo_run, tmo_hit, rewind_req;
    logic [PTR_W-1:0]  ack_base, snd_base, snd_next;
    logic [RTY_W-1:0]  retry_eff;

    // ---------------------------------------------------------------- write side
    assign wr_en       = i_valid && ready_q;
    assign wr_restart  = i_sof && (wr_off_q != '0);
    assign wr_addr_off = wr_restart ? '0 : wr_off_q;

    always_comb begin
        wr_off_d = wr_off_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            if (wr_addr_off == LAST_OFF) begin
                wr_off_d = '0;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_off_d = wr_addr_off + OFF_W'(1);
            end
        end
    end

    arq_replay_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (IDX_W + OFF_W)
    ) u_ram (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr ({wr_ptr_q[IDX_W-1:0], wr_addr_off}),
        .wdata (i_data),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

    // ---------------------------------------------------------------- read / ARQ control
    assign hs         = valid_q && i_ready;
    assign last_beat  = rd_off_q == LAST_OFF;
    assign frame_done = (st_q == StSend) && hs && last_beat;
    assign boundary   = (st_q == StIdle) || frame_done;

    assign ack_evt = arq_en_q && i_ack_valid && (i_ack_nak == ACK_CODE)
                     && (snd_ptr_q != ack_ptr_q);
    assign tmo_run = arq_en_q && (st_q == StIdle) && (snd_ptr_q != ack_ptr_q);
    assign tmo_hit = tmo_run && (tmo_q == TMO_LAST);
    assign nak_evt = arq_en_q && (snd_ptr_q != ack_ptr_q)
                     && ((i_ack_valid && (i_ack_nak == NAK_CODE)) || tmo_hit);

    assign rewind_req = rewind_q || nak_evt;
    assign ack_base   = ack_ptr_q + PTR_W'(ack_evt);
    assign snd_base   = snd_ptr_q + PTR_W'(frame_done);
    assign retry_eff  = ack_evt ? '0 : retry_q;

    always_comb begin
        st_d      = st_q;
        snd_ptr_d = snd_ptr_q;
        ack_ptr_d = ack_base;
        rd_off_d  = rd_off_q;
        valid_d   = valid_q;
        sof_d     = sof_q;
        rewind_d  = rewind_req;
        retry_d   = retry_eff;
        arq_en_d  = arq_en_q;
        retrans_d = 1'b0;
        err_d     = 1'b0;
        re        = 1'b0;
        raddr     = '0;
        snd_next  = snd_base;

        tmo_d = tmo_q;
        if (!arq_en_q || ack_evt) begin
            tmo_d = '0;
        end else if (tmo_run) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (hs && !last_beat) begin
            re       = 1'b1;
            raddr    = {snd_ptr_q[IDX_W-1:0], rd_off_q + OFF_W'(1)};
            rd_off_d = rd_off_q + OFF_W'(1);
            sof_d    = 1'b0;
        end

        if (boundary) begin
            arq_en_d = i_arq_en;
            if (!arq_en_q) begin
                ack_ptr_d = snd_base;
                rewind_d  = 1'b0;
            end else if (rewind_req) begin
                rewind_d = 1'b0;
                tmo_d    = '0;
                if (snd_base != ack_base) begin
                    // Retry budget exhausted: give up on the oldest frame, replay the rest.
                    if ((32'(retry_eff) + 32'd1) >= MAX_RETRY) begin
                        ack_ptr_d = ack_base + PTR_W'(1);
                        snd_next  = ack_base + PTR_W'(1);
                        retry_d   = '0;
                        err_d     = 1'b1;
                    end else begin
                        snd_next  = ack_base;
                        retry_d   = retry_eff + RTY_W'(1);
                    end
                    retrans_d = snd_next != wr_ptr_q;
                end
            end
            snd_ptr_d = snd_next;
            if (snd_next != wr_ptr_q) begin
                st_d     = StSend;
                re       = 1'b1;
                raddr    = {snd_next[IDX_W-1:0], {OFF_W{1'b0}}};
                rd_off_d = '0;
                valid_d  = 1'b1;
                sof_d    = 1'b1;
            end else begin
                st_d    = StIdle;
                valid_d = 1'b0;
                sof_d   = 1'b0;
            end
        end
    end

    assign ready_d = (wr_ptr_d - ack_ptr_d) != FULL_CNT;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q      <= StIdle;
            wr_ptr_q  <= '0;
            snd_ptr_q <= '0;
            ack_ptr_q <= '0;
            wr_off_q  <= '0;
            rd_off_q  <= '0;
            tmo_q     <= '0;
            retry_q   <= '0;
            rewind_q  <= 1'b0;
            arq_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            ready_q   <= 1'b0;
            retrans_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            wr_ptr_q  <= wr_ptr_d;
            snd_ptr_q <= snd_ptr_d;
            ack_ptr_q <= ack_ptr_d;
            wr_off_q  <= wr_off_d;
            rd_off_q  <= rd_off_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            rewind_q  <= rewind_d;
            arq_en_q  <= arq_en_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            ready_q   <= ready_d;
            retrans_q <= retrans_d;
            err_q     <= err_d;
        end
    end

    assign o_ready       = ready_q;
    assign o_valid       = valid_q;
    assign o_sof         = sof_q;
    assign o_data        = valid_q ? rdata : '0;
    assign o_frames_held = wr_ptr_q - ack_ptr_q;
    assign o_retrans     = retrans_q;
    assign o_err         = err_q;

`ifdef ARQ_REPLAY_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stat_tx_frames <= '0;
            o_stat_retrans   <= '0;
            o_stat_drops     <= '0;
        end else begin
            if (frame_done && (o_stat_tx_frames != '1)) begin
                o_stat_tx_frames <= o_stat_tx_frames + 32'd1;
            end
            if (retrans_d && (o_stat_retrans != '1)) begin
                o_stat_retrans <= o_stat_retrans + 16'd1;
            end
            if (err_d && (o_stat_drops != '1)) begin
                o_stat_drops <= o_stat_drops + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arq_replay_buffer.sv
// Scoreboard bench for arq_replay_buffer: expected beats queued at stimulus, popped on handshake.
module tb_arq_replay_buffer;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned WINDOW    = 4;
    localparam int unsigned TIMEOUT   = 32;
    localparam int unsigned MAX_RETRY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_data = '0;
    logic        i_valid = 1'b0, i_sof = 1'b0;
    logic        o_ready, o_valid, o_sof;
    logic [7:0]  o_data;
    logic        i_ready;
    logic        ack_valid = 1'b0, ack_nak = 1'b0, arq_en = 1'b1;
    logic [2:0]  frames_held;
    logic        retrans, err;
`ifdef ARQ_REPLAY_STATS_EN
    logic [31:0] stat_tx;
    logic [15:0] stat_rt, stat_dr;
`endif

    arq_replay_buffer #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .WINDOW    (WINDOW),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .i_sof         (i_sof),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_sof         (o_sof),
        .i_ready       (i_ready),
        .i_ack_valid   (ack_valid),
        .i_ack_nak     (ack_nak),
        .i_arq_en      (arq_en),
        .o_frames_held (frames_held),
        .o_retrans     (retrans),
        .o_err         (err)
`ifdef ARQ_REPLAY_STATS_EN
        ,
        .o_stat_tx_frames (stat_tx),
        .o_stat_retrans   (stat_rt),
        .o_stat_drops     (stat_dr)
`endif
    );

    initial forever #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_retrans = 0;
    int         n_drop = 0;
    int         rdy_mode = 1;
    bit         chk_stable = 1'b0;
    logic       stall_q = 1'b0;
    logic [8:0] stall_val = '0;
    logic [8:0] exp_beat;
    logic [8:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sink backpressure: 0 = stalled, 1 = always ready, 2 = random.
    initial begin
        i_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       i_ready = 1'b0;
                1:       i_ready = 1'b1;
                default: i_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (retrans) n_retrans++;
            if (err) n_drop++;
            if (chk_stable && stall_q) begin
                check("stall_valid", 32'(o_valid), 32'd1);
                check("stall_beat", 32'({o_sof, o_data}), 32'(stall_val));
            end
            stall_q   = o_valid && !i_ready;
            stall_val = {o_sof, o_data};
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'(sb.size()), 32'd1);
                end else begin
                    exp_beat = sb.pop_front();
                    check("beat", 32'({o_sof, o_data}), 32'(exp_beat));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic put_beat(input logic [7:0] d, input logic s);
        int t = 0;
        i_data  = d;
        i_sof   = s;
        i_valid = 1'b1;
        @(negedge clk);
        while (!o_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) check("write_accept", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    task automatic write_frame(input logic [7:0] base);
        for (int k = 0; k < FRAME_LEN; k++) sb.push_back({k == 0, base + 8'(k)});
        for (int k = 0; k < FRAME_LEN; k++) put_beat(base + 8'(k), k == 0);
    endtask

    task automatic push_frame(input logic [7:0] base);
        for (int k = 0; k < FRAME_LEN; k++) sb.push_back({k == 0, base + 8'(k)});
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 600) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack(input logic nak);
        @(posedge clk);
        #1;
        ack_valid = 1'b1;
        ack_nak   = nak;
        @(posedge clk);
        #1;
        ack_valid = 1'b0;
        ack_nak   = 1'b0;
    endtask

    task automatic apply_reset(input logic en);
        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_sof     = 1'b0;
        i_data    = '0;
        ack_valid = 1'b0;
        ack_nak   = 1'b0;
        arq_en    = en;
        rdy_mode  = 1;
        repeat (3) @(posedge clk);
        sb.delete();
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int r0;
        int d0;

        // Reset values
        #12;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_sof", 32'(o_sof), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_held", 32'(frames_held), 32'd0);
        check("rst_pulses", 32'({retrans, err}), 32'd0);

        // 1: two frames, each acknowledged
        apply_reset(1'b1);
        check("t1_ready", 32'(o_ready), 32'd1);
        write_frame(8'h10);
        drain("t1_drain_a");
        check("t1_held_unacked", 32'(frames_held), 32'd1);
        pulse_ack(1'b0);
        write_frame(8'h20);
        drain("t1_drain_b");
        pulse_ack(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("t1_held_end", 32'(frames_held), 32'd0);

        // 2: window full blocks the fifth frame until an ACK frees a slot
        apply_reset(1'b1);
        for (int f = 0; f < 4; f++) write_frame(8'h30 + 8'(f * 16));
        fork
            write_frame(8'h70);
            begin
                repeat (4) @(negedge clk);
                check("t2_ready_full", 32'(o_ready), 32'd0);
                check("t2_held_full", 32'(frames_held), 32'd4);
                pulse_ack(1'b0);
            end
        join
        drain("t2_drain");
        check("t2_held_after", 32'(frames_held), 32'd4);

        // 3: NAK mid-frame; current frame completes, then replay from the oldest
        apply_reset(1'b1);
        write_frame(8'h60);
        write_frame(8'h70);
        write_frame(8'h80);
        r0 = n_retrans;
        t  = 0;
        while (!(o_valid && o_data == 8'h81) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t3_f3_beat1", 32'(o_data), 32'h81);
        ack_valid = 1'b1;
        ack_nak   = 1'b1;
        push_frame(8'h60);
        push_frame(8'h70);
        push_frame(8'h80);
        @(negedge clk);
        ack_valid = 1'b0;
        ack_nak   = 1'b0;
        t = 0;
        while (!retrans && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t3_replay_head", 32'({retrans, o_sof, o_data}), 32'h360);
        drain("t3_drain");
        check("t3_retrans_cnt", 32'(n_retrans - r0), 32'd1);

        // 4: timeout replay, second timeout drops the frame
        apply_reset(1'b1);
        write_frame(8'h90);
        drain("t4_first_send");
        push_frame(8'h90);
        r0 = n_retrans;
        t  = 0;
        while (n_retrans == r0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t4_replay", 32'(n_retrans - r0), 32'd1);
        check("t4_tmo_window", 32'(t >= 24 && t <= 40), 32'd1);
        drain("t4_replay_drain");
        d0 = n_drop;
        t  = 0;
        while (n_drop == d0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t4_drop", 32'(n_drop - d0), 32'd1);
        repeat (3) @(negedge clk);
        check("t4_held_zero", 32'(frames_held), 32'd0);
        check("t4_idle", 32'(o_valid), 32'd0);

        // 5: fire-and-forget with backpressure, ACK/NAK ignored
        apply_reset(1'b0);
        rdy_mode = 0;
        r0       = n_retrans;
        write_frame(8'hA0);
        pulse_ack(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("t5_ack_ignored", 32'(frames_held), 32'd1);
        pulse_ack(1'b1);
        write_frame(8'hB0);
        check("t5_held_two", 32'(frames_held), 32'd2);
        chk_stable = 1'b1;
        rdy_mode   = 2;
        drain("t5_drain");
        chk_stable = 1'b0;
        rdy_mode   = 1;
        check("t5_freed", 32'(frames_held), 32'd0);
        check("t5_no_retrans", 32'(n_retrans - r0), 32'd0);

        // 6: SOF mid-frame restarts the frame; then reset mid-frame
        apply_reset(1'b1);
        push_frame(8'hD0);
        put_beat(8'hC0, 1'b1);
        put_beat(8'hC1, 1'b0);
        put_beat(8'hD0, 1'b1);
        put_beat(8'hD1, 1'b0);
        put_beat(8'hD2, 1'b0);
        put_beat(8'hD3, 1'b0);
        drain("t6_drain");
        check("t6_held", 32'(frames_held), 32'd1);
        pulse_ack(1'b0);
        write_frame(8'hE0);
        t = 0;
        while (!(o_valid && o_data == 8'hE1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t6_midframe", 32'(o_data), 32'hE1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(o_valid), 32'd0);
        check("t6_rst_held", 32'(frames_held), 32'd0);
        check("t6_rst_data", 32'(o_data), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_post_idle", 32'(o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arq_replay_buffer.md
Name: arq_replay_buffer

Overview:
Parametrised go-back-N ARQ transmit buffer for the sender path. It replaces the single-frame line FIFO with a window of up to WINDOW stored frames. It sits between the mapper (frame byte stream with FAS marker) and the line serializer. Frames are held until acknowledged; on a NAK or a timeout it replays every frame from the oldest unacknowledged one.

Parameters:
DATA_W, 8, byte width of the frame data path
FRAME_LEN, 16, beats per frame (>=2)
WINDOW, 4, maximum stored/outstanding frames (power of 2, >=2)
TIMEOUT, 4096, cycles to wait for an ACK/NAK before an automatic replay
MAX_RETRY, 3, replays of one frame before it is discarded

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_data  in  DATA_W  frame beat from the mapper
i_valid  in  1  i_data valid
i_sof  in  1  first beat of a frame (FAS)
o_ready  out  1  buffer can accept a beat
o_data  out  DATA_W  beat to the line serializer
o_valid  out  1  o_data valid
o_sof  out  1  first beat of the outgoing frame
i_ready  in  1  serializer accepts the beat
i_ack_valid  in  1  one-cycle ACK/NAK strobe from the receiver path
i_ack_nak  in  1  qualifies i_ack_valid: 1 = NAK, 0 = ACK
i_arq_en  in  1  0 = fire-and-forget (frame freed when fully sent)
o_frames_held  out  clog2(WINDOW)+1  stored frames not yet freed
o_retrans  out  1  one-cycle pulse when a replay starts
o_err  out  1  one-cycle pulse when a frame is dropped after MAX_RETRY

Behaviour:
- Reset values: all outputs 0. Pointers, counters and FSM go to IDLE. Stored data is don't-care.
- Storage: WINDOW x 2^clog2(FRAME_LEN) entries with synchronous read. The address is {frame_idx, beat_off}.
- Pointers: wr_ptr, snd_ptr and ack_ptr, each clog2(WINDOW)+1 bits so wrap-around is unambiguous.
  - held = wr_ptr - ack_ptr.
  - Full when held == WINDOW.
- Write side:
  - o_ready = !full.
  - A beat is accepted on i_valid && o_ready. The write offset increments; wr_ptr advances after beat FRAME_LEN-1.
  - i_sof at a nonzero offset discards the partial frame and restarts it at offset 0.
  - i_sof is not required at offset 0.
- Read FSM: IDLE -> SEND when snd_ptr != wr_ptr.
  - SEND streams FRAME_LEN beats using AXIS rules. o_data, o_sof and o_valid stay stable while !i_ready. o_sof is set on beat 0.
  - After the last beat, snd_ptr advances. The FSM goes to SEND if more frames are sendable, otherwise to IDLE.
  - First beat appears at most 2 cycles after a frame becomes sendable. At steady state, a beat is presented every cycle that i_ready is high.
- ACK (i_arq_en=1):
  - ACK frees the oldest frame: ack_ptr++, retry count cleared, timeout counter cleared.
  - ACK is ignored when snd_ptr == ack_ptr (nothing sent).
- NAK:
  - A NAK sets rewind_pend. At the next frame boundary (immediately if IDLE, otherwise after the current last beat), snd_ptr <= ack_ptr, o_retrans pulses and the retry count increments.
  - A NAK with nothing outstanding is ignored.
  - A second NAK while rewind_pend is set is absorbed.
- Timeout: the counter runs while snd_ptr != ack_ptr and the FSM is not mid-frame. Reaching TIMEOUT-1 acts as a NAK.
- Retry limit: when a rewind would make the retry count reach MAX_RETRY, the oldest frame is dropped instead.
  - ack_ptr++ and o_err pulses.
  - Replay restarts from the new ack_ptr; if that frame does not exist, the FSM goes to IDLE.
- i_arq_en=0: ack_ptr follows snd_ptr. ACK/NAK and the timeout are ignored, and no retries occur.
  - Toggling i_arq_en takes effect at the next frame boundary only.
- Simultaneous write-complete and ACK in one cycle: held is unchanged.
- Reset asserted mid-frame: all state clears at once and o_valid drops asynchronously. Frames in flight are lost.

Optional Feature:
ARQ_REPLAY_STATS_EN:
- Defined: adds outputs o_stat_tx_frames (32b, frames fully sent including replays), o_stat_retrans (16b) and o_stat_drops (16b).
  - Counters are saturating and cleared by reset.
- Undefined: ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package arq_pkg:
  - FSM state typedef (IDLE, SEND)
  - ACK/NAK encoding constants
  - clog2-derived width localparams
- One sub-module, arq_replay_ram: simple dual-port, 1 write / 1 registered read, inferable as BRAM/LUTRAM.
- Pointer, timeout and FSM logic stay in the top module.

Test Plan:
All cases use DATA_W=8, FRAME_LEN=4, WINDOW=4, TIMEOUT=32, MAX_RETRY=2 unless noted.
1. Write frames 0x10-13 and 0x20-23 with i_ready=1 and ACK after each -> output 10,11,12,13,20,21,22,23, o_sof on 10/20, o_frames_held ends at 0.
2. Write 5 frames with no ACK -> o_ready=0 after the 4th frame; frame 5 is accepted only after the first ACK.
3. Send 3 frames, then NAK while frame 3 beat 1 is on the bus -> frame 3 completes, then o_retrans pulses and frames 1,2,3 replay in order.
4. Send 1 frame with no ACK -> replay at 32 idle cycles; second timeout -> o_err pulses, frame dropped, o_frames_held=0.
5. i_arq_en=0, write 2 frames, random i_ready backpressure -> data is stable while stalled, frames are freed after their last beat, ACKs are ignored.
6. i_sof at offset 2 of a frame -> partial beats discarded; the next 4 beats form the stored frame; assert reset mid-frame -> o_valid=0 immediately.
